// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect strobe and decode handshake.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            misalign_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, misalign_err,
    input  imem_ack, imem_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, misalign_err,
    output imem_ack, imem_data, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a DEPTH-entry prefetch buffer and redirect handling.
// Optional FETCH_MISALIGN_EN: misaligned redirects raise misalign_err and halt fetch.
module fetch_unit #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] stale_q, stale_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     data_mem_q [DEPTH];

  logic            req_c, xfer_c, push_c, pop_c, halt_c, valid_c;
  logic [XLEN-1:0] redir_pc_c;

  assign req_c   = (state_q == S_REQ) || (state_q == S_DROP);
  assign valid_c = (count_q != '0);
  assign xfer_c  = req_c & bus.imem_ack;
  assign push_c  = (state_q == S_REQ) & xfer_c & ~bus.redirect;
  assign pop_c   = valid_c & bus.inst_ready & ~bus.redirect;
  assign halt_c  = misalign_d;

  assign bus.imem_req     = req_c;
  assign bus.imem_addr    = (state_q == S_DROP) ? stale_q : fetch_pc_q;
  assign bus.inst_valid   = valid_c;
  assign bus.inst         = data_mem_q[rd_ptr_q];
  assign bus.inst_pc      = pc_mem_q[rd_ptr_q];
  assign bus.misalign_err = misalign_q;

`ifdef FETCH_MISALIGN_EN
  assign redir_pc_c = bus.redirect_pc;
  assign misalign_d = bus.redirect ? (bus.redirect_pc[1:0] != 2'b00) : misalign_q;
`else
  logic unused_redir_lo;
  assign unused_redir_lo = ^bus.redirect_pc[1:0];
  assign redir_pc_c      = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign misalign_d      = 1'b0;
`endif

  // Next-state: redirect flushes the buffer and wins over any push/pop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (bus.redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redir_pc_c;
    end else begin
      if (push_c) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    case (state_q)
      S_IDLE: begin
        if (!halt_c && (count_d < CW'(DEPTH))) state_d = S_REQ;
      end
      S_REQ: begin
        // Outstanding request must still be answered; remember its address.
        if (bus.redirect && !bus.imem_ack) begin
          state_d = S_DROP;
          stale_d = fetch_pc_q;
        end else if (halt_c || (count_d == CW'(DEPTH))) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.imem_ack) state_d = halt_c ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      stale_q    <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      misalign_q <= misalign_d;
    end
  end

  // Buffer storage needs no reset: contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      data_mem_q[wr_ptr_q] <= bus.imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a queue-based model of the fetched instruction stream.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit_if #(.XLEN(8))  bus8 ();

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_unit #(.XLEN(8), .DEPTH(DEPTH), .RESET_PC(8'hFC)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory model: every address returns a distinct, predictable word.
  assign bus.imem_data  = hash(bus.imem_addr);
  assign bus8.imem_data = hash({24'h0, bus8.imem_addr});

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.imem_ack  = 1'b0; bus.redirect  = 1'b0; bus.redirect_pc  = '0; bus.inst_ready  = 1'b0;
    bus8.imem_ack = 1'b0; bus8.redirect = 1'b0; bus8.redirect_pc = '0; bus8.inst_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.inst_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      failures++; $display("FAIL %s timeout inst_valid got=%b exp=1", name, bus.inst_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.inst_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", bus.misalign_err); end
    checks++; if (bus8.imem_addr !== 8'hFC) begin failures++; $display("FAIL rst_addr8 got=%h exp=fc", bus8.imem_addr); end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL first_edge_req got=%b exp=1", bus.imem_req); end
    step();
    // Reset in the middle of an unacknowledged request: abandoned, no DROP.
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL midrst_req got=%b exp=0", bus.imem_req); end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      failures++; $display("FAIL midrst_resume got req=%b addr=%h exp req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    bus.imem_ack = 1'b1; bus.inst_ready = 1'b1;
    wait_valid("stream");
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * k)) begin
        failures++; $display("FAIL stream_pc%0d got valid=%b pc=%h exp pc=%h", k, bus.inst_valid, bus.inst_pc, 32'(4 * k));
      end
      checks++; if (bus.inst !== hash(32'(4 * k))) begin
        failures++; $display("FAIL stream_inst%0d got=%h exp=%h", k, bus.inst, hash(32'(4 * k)));
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    int xfers = 0;
    apply_reset();
    bus.imem_ack = 1'b1; bus.inst_ready = 1'b0;
    repeat (12) begin
      if (bus.imem_req === 1'b1) xfers++;
      step();
    end
    checks++; if (xfers != DEPTH) begin failures++; $display("FAIL full_xfers got=%0d exp=%0d", xfers, DEPTH); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
      failures++; $display("FAIL full_head got valid=%b pc=%h exp valid=1 pc=0", bus.inst_valid, bus.inst_pc);
    end
    idle_inputs();
  endtask

  task automatic test_drop();
    apply_reset();
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin
      failures++; $display("FAIL drop_hold got req=%b addr=%h valid=%b exp 1/0/0", bus.imem_req, bus.imem_addr, bus.inst_valid);
    end
    step(); step();
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL drop_stable got=%h exp=0", bus.imem_addr); end
    bus.imem_ack = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin
      failures++; $display("FAIL drop_next got req=%b addr=%h valid=%b exp 1/100/0", bus.imem_req, bus.imem_addr, bus.inst_valid);
    end
    bus.inst_ready = 1'b1;
    step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst !== hash(32'h100)) begin
      failures++; $display("FAIL drop_first got valid=%b pc=%h inst=%h exp pc=100 inst=%h", bus.inst_valid, bus.inst_pc, bus.inst, hash(32'h100));
    end
    idle_inputs();
  endtask

  task automatic test_redirect_full();
    apply_reset();
    bus.imem_ack = 1'b1;
    repeat (8) step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL rf_full got valid=%b req=%b exp 1/0", bus.inst_valid, bus.imem_req);
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200; bus.inst_ready = 1'b1;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rf_flush got=%b exp=0", bus.inst_valid); end
    wait_valid("rf");
    checks++; if (bus.inst_pc !== 32'h200) begin failures++; $display("FAIL rf_pc got=%h exp=200", bus.inst_pc); end
    idle_inputs();
  endtask

  task automatic test_wrap8();
    int n = 0;
    apply_reset();
    bus8.imem_ack = 1'b1; bus8.inst_ready = 1'b1;
    while (bus8.inst_valid !== 1'b1 && n < 8) begin step(); n++; end
    checks++; if (bus8.inst_valid !== 1'b1 || bus8.inst_pc !== 8'hFC || bus8.inst !== hash(32'hFC)) begin
      failures++; $display("FAIL wrap_fc got valid=%b pc=%h inst=%h exp pc=fc", bus8.inst_valid, bus8.inst_pc, bus8.inst);
    end
    step();
    checks++; if (bus8.inst_valid !== 1'b1 || bus8.inst_pc !== 8'h00 || bus8.inst !== hash(32'h0)) begin
      failures++; $display("FAIL wrap_00 got valid=%b pc=%h inst=%h exp pc=00", bus8.inst_valid, bus8.inst_pc, bus8.inst);
    end
    idle_inputs();
  endtask

  task automatic test_misalign();
    apply_reset();
    bus.imem_ack = 1'b1; bus.inst_ready = 1'b1;
    repeat (4) step();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h102;
    step();
    bus.redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
    checks++; if (bus.misalign_err !== 1'b1) begin failures++; $display("FAIL mis_set got=%b exp=1", bus.misalign_err); end
    repeat (3) step();
    checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.misalign_err !== 1'b1) begin
      failures++; $display("FAIL mis_halt got req=%b valid=%b err=%b exp 0/0/1", bus.imem_req, bus.inst_valid, bus.misalign_err);
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h104;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", bus.misalign_err); end
    wait_valid("mis");
    checks++; if (bus.inst_pc !== 32'h104) begin failures++; $display("FAIL mis_resume got=%h exp=104", bus.inst_pc); end
`else
    checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL mis_tied got=%b exp=0", bus.misalign_err); end
    wait_valid("align");
    checks++; if (bus.inst_pc !== 32'h100) begin failures++; $display("FAIL align_pc got=%h exp=100", bus.inst_pc); end
`endif
    idle_inputs();
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    logic [31:0] nf = 32'h0;
    logic [31:0] stale = 32'h0;
    logic [31:0] rpc;
    logic        drop = 1'b0;
    logic        live = 1'b0;
    logic        req, valid;
    int          sz_before;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.imem_ack    = ($urandom_range(0, 3) != 0);
      bus.inst_ready  = ($urandom_range(0, 2) != 0);
      bus.redirect    = ($urandom_range(0, 19) == 0);
      rpc             = $urandom;
`ifdef FETCH_MISALIGN_EN
      rpc[1:0]        = 2'b00;
`endif
      bus.redirect_pc = rpc;
      #1;
      req   = bus.imem_req;
      valid = bus.inst_valid;
      checks++; if (valid !== (q.size() != 0)) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++; if (bus.inst_pc !== q[0].pc || bus.inst !== q[0].data) begin
          failures++; $display("FAIL rnd_head cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, bus.inst_pc, bus.inst, q[0].pc, q[0].data);
        end
      end
      if (req === 1'b1) begin
        checks++; if (bus.imem_addr !== (drop ? stale : nf)) begin
          failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, drop ? stale : nf);
        end
      end
      if (q.size() == DEPTH) begin
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL rnd_full_req cyc=%0d got=%b exp=0", cyc, req); end
      end
      if (drop || live) begin
        checks++; if (req !== 1'b1) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=1", cyc, req); end
      end

      // Advance the model across the coming edge.
      sz_before = q.size();
      if (bus.redirect) begin
        q.delete();
        if (!drop) stale = nf;
        drop = req && !bus.imem_ack;
        nf   = {rpc[31:2], 2'b00};
      end else begin
        if (valid && bus.inst_ready && q.size() != 0) void'(q.pop_front());
        if (req && bus.imem_ack) begin
          if (drop) drop = 1'b0;
          else begin
            q.push_back('{pc: nf, data: hash(nf)});
            nf = nf + 32'd4;
          end
        end
      end
      live = !drop && (q.size() < DEPTH) && (sz_before < DEPTH);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_full();
    test_drop();
    test_redirect_full();
    test_wrap8();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
